// File: rtl/lbi_pkg.sv
// Shared types and helpers for the LBI matrix-vector row engine.
package lbi_pkg;

    localparam int ELEM_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lbi_state_e;

    // Beats per job: message bits rounded up to whole chunks.
    function automatic int lbi_nchunk(input int msg_w, input int chunk_w);
        return (msg_w + chunk_w - 1) / chunk_w;
    endfunction

endpackage

// File: rtl/lbi_masked_sum.sv
// Combinational masked sum of CHUNK_W elements through a balanced adder tree,
// every node ELEM_W wide so each add wraps modulo 2^ELEM_W.
module lbi_masked_sum #(
    parameter int CHUNK_W = 16,
    parameter int ELEM_W  = 6
) (
    input  logic [CHUNK_W-1:0]        mask,
    input  logic [CHUNK_W*ELEM_W-1:0] elem,
    output logic [ELEM_W-1:0]         sum
);

    localparam int LVL    = (CHUNK_W <= 1) ? 0 : $clog2(CHUNK_W);
    localparam int LEAVES = 1 << LVL;

    // Level 0 holds the masked leaves, padded with zero up to a power of two.
    for (genvar l = 0; l <= LVL; l++) begin : g_lvl
        logic [(LEAVES >> l)*ELEM_W-1:0] v;
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < LEAVES; i++) begin : g_in
                if (i < CHUNK_W) begin : g_used
                    assign v[i*ELEM_W +: ELEM_W] = mask[i] ? elem[i*ELEM_W +: ELEM_W] : '0;
                end else begin : g_pad
                    assign v[i*ELEM_W +: ELEM_W] = '0;
                end
            end
        end else begin : g_node
            for (genvar i = 0; i < (LEAVES >> l); i++) begin : g_add
                assign v[i*ELEM_W +: ELEM_W] = g_lvl[l-1].v[(2*i)*ELEM_W +: ELEM_W]
                                             + g_lvl[l-1].v[(2*i+1)*ELEM_W +: ELEM_W];
            end
        end
    end

    assign sum = g_lvl[LVL].v[ELEM_W-1:0];

endmodule

// File: rtl/lbi_matvec_rows.sv
// NROWS parallel masked inner products mod 2^ELEM_W over a captured message,
// fed by a valid/ready stream of random elements, one chunk per beat.
//
// state | meaning
// IDLE  | waiting for start; message capture on accept
// RUN   | accepting random beats, accumulating each row
// DONE  | result held on out_data until out_ready
module lbi_matvec_rows
    import lbi_pkg::*;
#(
    parameter int MSG_W   = 840,
    parameter int CHUNK_W = 16,
    parameter int ELEM_W  = ELEM_W_DEFAULT,
    parameter int NROWS   = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [MSG_W-1:0]                  msg_in,
    input  logic                              start,
    output logic                              busy,
    input  logic [NROWS*CHUNK_W*ELEM_W-1:0]   rand_data,
    input  logic                              rand_valid,
    output logic                              rand_ready,
    output logic [NROWS*ELEM_W-1:0]           out_data,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int NCHUNK = lbi_nchunk(MSG_W, CHUNK_W);
    localparam int PAD_W  = NCHUNK * CHUNK_W;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    lbi_state_e state_q, state_d;

    logic [CNT_W-1:0]        cnt_q;
    logic [PAD_W-1:0]        msg_q;
    logic [ELEM_W-1:0]       acc_q    [NROWS];
    logic [ELEM_W-1:0]       acc_next [NROWS];
    logic [ELEM_W-1:0]       row_sum  [NROWS];
    logic [NROWS*ELEM_W-1:0] acc_next_flat;
    logic [NROWS*ELEM_W-1:0] out_data_q;
    logic                    start_acc;
    logic                    beat;
    logic                    last_beat;

    assign start_acc = (state_q == IDLE) && start;
    assign beat      = rand_valid && rand_ready;
    assign last_beat = (cnt_q == CNT_W'(NCHUNK - 1));

    // The message shifts down a chunk per beat, so the low chunk is always the live mask.
    for (genvar r = 0; r < NROWS; r++) begin : g_row
        lbi_masked_sum #(
            .CHUNK_W (CHUNK_W),
            .ELEM_W  (ELEM_W)
        ) u_sum (
            .mask (msg_q[CHUNK_W-1:0]),
            .elem (rand_data[r*CHUNK_W*ELEM_W +: CHUNK_W*ELEM_W]),
            .sum  (row_sum[r])
        );
        assign acc_next[r] = acc_q[r] + row_sum[r];
        assign acc_next_flat[r*ELEM_W +: ELEM_W] = acc_next[r];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (beat && last_beat) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        rand_ready = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            RUN: begin
                busy       = 1'b1;
                rand_ready = 1'b1;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            msg_q      <= '0;
            out_data_q <= '0;
            for (int r = 0; r < NROWS; r++) acc_q[r] <= '0;
        end else if (start_acc) begin
            cnt_q <= '0;
            msg_q <= PAD_W'(msg_in);
            for (int r = 0; r < NROWS; r++) acc_q[r] <= '0;
        end else if (beat) begin
            cnt_q <= cnt_q + CNT_W'(1);
            msg_q <= msg_q >> CHUNK_W;
            for (int r = 0; r < NROWS; r++) acc_q[r] <= acc_next[r];
            if (last_beat) out_data_q <= acc_next_flat;
        end
    end

    assign out_data = out_data_q;

endmodule

// File: tb/tb_lbi_matvec_rows.sv
// Self-checking bench for lbi_matvec_rows: behavioural reference model plus
// directed and randomized jobs.
module tb_lbi_matvec_rows;

    localparam int MSG_W   = 840;
    localparam int CHUNK_W = 16;
    localparam int ELEM_W  = 6;
    localparam int NROWS   = 4;
    localparam int NCHUNK  = (MSG_W + CHUNK_W - 1) / CHUNK_W;
    localparam int RW      = NROWS * CHUNK_W * ELEM_W;
    localparam int OW      = NROWS * ELEM_W;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [MSG_W-1:0] msg_in = '0;
    logic             start = 1'b0;
    logic             busy;
    logic [RW-1:0]    rand_data = '0;
    logic             rand_valid = 1'b0;
    logic             rand_ready;
    logic [OW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;

    lbi_matvec_rows #(
        .MSG_W   (MSG_W),
        .CHUNK_W (CHUNK_W),
        .ELEM_W  (ELEM_W),
        .NROWS   (NROWS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .msg_in     (msg_in),
        .start      (start),
        .busy       (busy),
        .rand_data  (rand_data),
        .rand_valid (rand_valid),
        .rand_ready (rand_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remember the message and every accepted beat, then
    // form each row's inner product directly over the MSG_W real message bits.
    int            m_phase = 0;
    logic [MSG_W-1:0] m_msg = '0;
    logic [RW-1:0] m_elems [NCHUNK];
    int            m_nbeat = 0;
    logic [OW-1:0] m_data = '0;

    function automatic logic [OW-1:0] ref_result();
        logic [OW-1:0] res;
        logic [RW-1:0] w;
        int s;
        res = '0;
        for (int r = 0; r < NROWS; r++) begin
            s = 0;
            for (int i = 0; i < MSG_W; i++) begin
                if (m_msg[i]) begin
                    w = m_elems[i / CHUNK_W];
                    s += int'(w[(r*CHUNK_W + i % CHUNK_W)*ELEM_W +: ELEM_W]);
                end
            end
            res[r*ELEM_W +: ELEM_W] = ELEM_W'(s % (1 << ELEM_W));
        end
        return res;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0;
            m_data  = '0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_msg   = msg_in;
                    m_nbeat = 0;
                    m_phase = 1;
                end
                1: if (rand_valid) begin
                    m_elems[m_nbeat] = rand_data;
                    m_nbeat++;
                    if (m_nbeat == NCHUNK) begin
                        m_data  = ref_result();
                        m_phase = 2;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    int dut_beats = 0;
    always @(negedge clk) begin
        if (reset_n && rand_valid && rand_ready) dut_beats++;
    end

    always @(negedge clk) begin
        check("busy",       64'(busy),       64'(m_phase != 0));
        check("rand_ready", 64'(rand_ready), 64'(m_phase == 1));
        check("out_valid",  64'(out_valid),  64'(m_phase == 2));
        check("out_data",   64'(out_data),   64'(m_data));
    end

    task automatic set_rand(input int emode, input int vmode, input int cyc);
        case (vmode)
            0:       rand_valid = 1'b1;
            1:       rand_valid = (cyc % 2 == 0);
            default: rand_valid = ($urandom_range(0, 2) != 0);
        endcase
        for (int r = 0; r < NROWS; r++) begin
            for (int j = 0; j < CHUNK_W; j++) begin
                case (emode)
                    0:       rand_data[(r*CHUNK_W+j)*ELEM_W +: ELEM_W] = 6'd1;
                    1:       rand_data[(r*CHUNK_W+j)*ELEM_W +: ELEM_W] = 6'd63;
                    2:       rand_data[(r*CHUNK_W+j)*ELEM_W +: ELEM_W] = (j == 0) ? 6'(r + 1) : 6'd5;
                    default: rand_data[(r*CHUNK_W+j)*ELEM_W +: ELEM_W] = 6'($urandom_range(0, 63));
                endcase
            end
        end
    endtask

    task automatic run_job(input logic [MSG_W-1:0] msg, input int emode, input int vmode,
                           input int hold, input bit pulse_start, input bit start_at_ack,
                           output int lat);
        @(posedge clk); #1;
        dut_beats = 0;
        msg_in    = msg;
        start     = 1'b1;
        out_ready = 1'b0;
        set_rand(emode, vmode, 0);
        lat = 0;
        forever begin
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (out_valid) break;
            if (lat > 2000) begin
                n_checks++;
                n_fail++;
                $display("FAIL job_timeout: out_valid still %0b after %0d cycles", out_valid, lat);
                break;
            end
            set_rand(emode, vmode, lat);
        end
        for (int h = 0; h < hold; h++) begin
            start = pulse_start && (h == hold / 2);
            set_rand(3, 2, h);
            @(posedge clk); #1;
        end
        start     = start_at_ack;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready  = 1'b0;
        rand_valid = 1'b0;
        check("idle_after_ack", 64'(busy), 64'(0));
    endtask

    localparam logic [OW-1:0] L8    = {4{6'd8}};
    localparam logic [OW-1:0] L56   = {4{6'd56}};
    localparam logic [OW-1:0] L4321 = {6'd4, 6'd3, 6'd2, 6'd1};

    initial begin
        logic [MSG_W-1:0] ones;
        logic [MSG_W-1:0] bit0;
        logic [MSG_W-1:0] rmsg;
        logic [OW-1:0]    held;
        int lat;
        int k;
        ones = '1;
        bit0 = '0;
        bit0[0] = 1'b1;

        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_data",   64'(out_data),   64'(0));
        check("reset_busy",       64'(busy),       64'(0));
        check("reset_rand_ready", 64'(rand_ready), 64'(0));
        check("reset_out_valid",  64'(out_valid),  64'(0));
        reset_n = 1'b1;

        run_job(ones, 0, 0, 0, 1'b0, 1'b0, lat);
        check("ones_latency", 64'(lat), 64'(NCHUNK + 1));
        check("ones_result",  64'(out_data), 64'(L8));
        check("ones_model",   64'(m_data),   64'(L8));
        check("ones_beats",   64'(dut_beats), 64'(NCHUNK));

        run_job(ones, 1, 0, 0, 1'b0, 1'b0, lat);
        check("wrap_result", 64'(out_data), 64'(L56));
        check("wrap_model",  64'(m_data),   64'(L56));

        run_job(bit0, 2, 0, 0, 1'b0, 1'b0, lat);
        check("bit0_result", 64'(out_data), 64'(L4321));
        check("bit0_model",  64'(m_data),   64'(L4321));

        run_job(ones, 0, 1, 0, 1'b0, 1'b0, lat);
        check("stall_result", 64'(out_data), 64'(L8));
        check("stall_beats",  64'(dut_beats), 64'(NCHUNK));

        for (int i = 0; i < MSG_W; i++) rmsg[i] = 1'($urandom_range(0, 1));
        run_job(rmsg, 3, 0, 10, 1'b1, 1'b0, lat);
        held = out_data;
        check("hold_result", 64'(held), 64'(m_data));

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < MSG_W; i++) rmsg[i] = 1'($urandom_range(0, 1));
            run_job(rmsg, 3, 2, $urandom_range(0, 5), 1'b1, 1'b0, lat);
            check("rand_beats", 64'(dut_beats), 64'(NCHUNK));
        end

        // Start held through the result handshake: ignored there, taken next cycle.
        run_job(ones, 0, 0, 2, 1'b0, 1'b1, lat);
        msg_in = ones;
        @(posedge clk); #1;
        start = 1'b0;
        check("restart_busy", 64'(busy), 64'(1));
        dut_beats = 0;
        set_rand(0, 0, 0);
        k = 0;
        while (dut_beats < 20 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("beats_before_reset", 64'(dut_beats), 64'(20));
        #2 reset_n = 1'b0;
        #1;
        check("async_busy",       64'(busy),       64'(0));
        check("async_rand_ready", 64'(rand_ready), 64'(0));
        check("async_out_valid",  64'(out_valid),  64'(0));
        rand_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        run_job(ones, 0, 0, 0, 1'b0, 1'b0, lat);
        check("post_reset_result",  64'(out_data), 64'(L8));
        check("post_reset_latency", 64'(lat),      64'(NCHUNK + 1));

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
